// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared constants and types for the RV32I load unit
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte-lane select and sign/zero extension of a loaded word
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - RV32I data-memory load path (optional LOAD_TIMEOUT_EN bus watchdog)
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [XLEN-1:0] i_ld_addr,
  input  logic [2:0]      i_ld_funct3,
  input  logic [4:0]      i_ld_rd,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_ld_done,
  output logic [XLEN-1:0] o_ld_data,
  output logic [4:0]      o_ld_rd_out,
  output logic [1:0]      o_ld_fault
);

  state_e          r_state;
  state_e          w_next;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_ld_data;
  logic [4:0]      r_ld_rd_out;
  logic [1:0]      r_ld_fault;
  logic            w_hs;
  logic            w_misalign;
  logic            w_illegal;
  logic            w_timeout;
  logic [XLEN-1:0] w_ext;

  assign w_hs = i_ld_valid && (r_state == IDLE);

  always_comb begin
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    case (i_ld_funct3)
      F3_LB, F3_LBU: w_misalign = 1'b0;
      F3_LH, F3_LHU: w_misalign = i_ld_addr[0];
      F3_LW:         w_misalign = |i_ld_addr[1:0];
      default:       w_illegal  = 1'b1;
    endcase
  end

  load_extract u_extract (
    .i_rdata  (i_mem_rdata),
    .i_offset (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] W_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] r_wait;

  // Counts completed REQ cycles; held at zero outside REQ so it is clear on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != REQ) r_wait <= '0;
    else                         r_wait <= r_wait + 1'b1;
  end

  assign w_timeout = (r_state == REQ) && !i_mem_ack && (r_wait == W_LIMIT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = (w_misalign || w_illegal) ? FAULT : REQ;
      REQ:     if (i_mem_ack) w_next = RESP;
               else if (w_timeout) w_next = FAULT;
      RESP:    w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_off       <= '0;
      r_f3        <= '0;
      r_rd        <= '0;
      r_mem_addr  <= '0;
      r_ld_data   <= '0;
      r_ld_rd_out <= '0;
      r_ld_fault  <= FLT_NONE;
    end else if (w_hs) begin
      r_off      <= i_ld_addr[1:0];
      r_f3       <= i_ld_funct3;
      r_rd       <= i_ld_rd;
      r_mem_addr <= {i_ld_addr[XLEN-1:2], 2'b00};
      // Faults resolve here, so the result registers are loaded for the next-cycle pulse.
      if (w_misalign || w_illegal) begin
        r_ld_data   <= '0;
        r_ld_rd_out <= i_ld_rd;
        r_ld_fault  <= w_illegal ? FLT_ILLEGAL : FLT_MISALIGN;
      end
    end else if (r_state == REQ && i_mem_ack) begin
      r_ld_data   <= w_ext;
      r_ld_rd_out <= r_rd;
      r_ld_fault  <= FLT_NONE;
    end else if (w_timeout) begin
      r_ld_data   <= '0;
      r_ld_rd_out <= r_rd;
      r_ld_fault  <= FLT_TIMEOUT;
    end
  end

  assign o_ld_ready  = (r_state == IDLE);
  assign o_mem_req   = (r_state == REQ);
  assign o_mem_addr  = r_mem_addr;
  assign o_ld_done   = (r_state == RESP) || (r_state == FAULT);
  assign o_ld_data   = r_ld_data;
  assign o_ld_rd_out = r_ld_rd_out;
  assign o_ld_fault  = r_ld_fault;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - randomized and directed checks of load_unit against a reference model
module tb_load_unit;

  localparam int TO = 4;
`ifdef LOAD_TIMEOUT_EN
  localparam int LONG_DELAY = TO;
`else
  localparam int LONG_DELAY = 5;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ld_valid = 1'b0;
  logic        o_ld_ready;
  logic [31:0] i_ld_addr = '0;
  logic [2:0]  i_ld_funct3 = '0;
  logic [4:0]  i_ld_rd = '0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_ld_done;
  logic [31:0] o_ld_data;
  logic [4:0]  o_ld_rd_out;
  logic [1:0]  o_ld_fault;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_data = '0;

  load_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ld_valid  (i_ld_valid),
    .o_ld_ready  (o_ld_ready),
    .i_ld_addr   (i_ld_addr),
    .i_ld_funct3 (i_ld_funct3),
    .i_ld_rd     (i_ld_rd),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_ld_done   (o_ld_done),
    .o_ld_data   (o_ld_data),
    .o_ld_rd_out (o_ld_rd_out),
    .o_ld_fault  (o_ld_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {fault[1:0], data[31:0]} from the RV32I load rules.
  function automatic logic [33:0] ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                           input logic [31:0] rdata);
    int unsigned off, b, h;
    logic [31:0] d;
    off = addr % 4;
    b = (rdata >> (8 * off)) % 256;
    h = (rdata >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0: begin d = (b >= 128) ? b + 32'hFFFF_FF00 : b; return {2'b00, d}; end
      3'd1: begin
        if (off % 2 != 0) return {2'b01, 32'd0};
        d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        return {2'b00, d};
      end
      3'd2: return (off != 0) ? {2'b01, 32'd0} : {2'b00, rdata};
      3'd4: return {2'b00, b};
      3'd5: return (off % 2 != 0) ? {2'b01, 32'd0} : {2'b00, h};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdata, input int delay, input bit junk);
    logic [33:0] r;
    r = ref_load(addr, f3, rdata);
    @(negedge i_clk);
    chk("idle_ready", o_ld_ready, 1);
    chk("idle_done", o_ld_done, 0);
    chk("hold_data", o_ld_data, last_data);
    i_ld_valid = 1'b1; i_ld_addr = addr; i_ld_funct3 = f3; i_ld_rd = rd;
    i_mem_ack = junk; i_mem_rdata = $urandom;
    @(negedge i_clk);
    i_ld_valid = 1'b0; i_mem_ack = 1'b0;
    if (r[33:32] != 2'b00) begin
      chk("flt_done", o_ld_done, 1);
      chk("flt_code", o_ld_fault, r[33:32]);
      chk("flt_data", o_ld_data, 0);
      chk("flt_rd", o_ld_rd_out, rd);
      chk("flt_noreq", o_mem_req, 0);
      last_data = 32'd0;
      return;
    end
    for (int i = 1; i <= delay; i++) begin
      if (i > 1) @(negedge i_clk);
      chk("req_high", o_mem_req, 1);
      chk("req_addr", o_mem_addr, {addr[31:2], 2'b00});
      chk("req_busy", o_ld_ready, 0);
      chk("req_nodone", o_ld_done, 0);
      if (junk) begin
        i_ld_valid = 1'b1; i_ld_addr = $urandom; i_ld_funct3 = 3'd2; i_ld_rd = 5'd31;
      end
      i_mem_ack = (i == delay);
      i_mem_rdata = (i == delay) ? rdata : $urandom;
    end
    @(negedge i_clk);
    i_ld_valid = 1'b0;
    i_mem_ack = junk; i_mem_rdata = $urandom;
    chk("rsp_done", o_ld_done, 1);
    chk("rsp_data", o_ld_data, r[31:0]);
    chk("rsp_rd", o_ld_rd_out, rd);
    chk("rsp_fault", o_ld_fault, 0);
    chk("rsp_noreq", o_mem_req, 0);
    chk("rsp_busy", o_ld_ready, 0);
    last_data = r[31:0];
  endtask

  initial begin
    logic [2:0] f3_tbl [8];
    f3_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", o_ld_ready, 1);
    chk("rst_req", o_mem_req, 0);
    chk("rst_done", o_ld_done, 0);
    chk("rst_data", o_ld_data, 0);
    chk("rst_rd", o_ld_rd_out, 0);
    chk("rst_fault", o_ld_fault, 0);
    chk("rst_maddr", o_mem_addr, 0);
    i_rst = 1'b0;

    do_load(32'h0000_0103, 3'd0, 5'd3, 32'h80FF_1234, 1, 1'b0);
    do_load(32'h0000_0102, 3'd5, 5'd4, 32'h8001_0000, 1, 1'b0);
    do_load(32'h0000_0102, 3'd1, 5'd5, 32'h8001_0000, 2, 1'b0);
    do_load(32'h0000_0202, 3'd2, 5'd6, 32'h1234_5678, 1, 1'b0);
    do_load(32'h0000_0200, 3'd3, 5'd7, 32'h1234_5678, 1, 1'b0);
    do_load(32'h0000_0040, 3'd2, 5'd9, 32'hCAFE_F00D, LONG_DELAY, 1'b1);

    // Reset two cycles into REQ, followed by a stale acknowledge.
    @(negedge i_clk);
    i_ld_valid = 1'b1; i_ld_addr = 32'h300; i_ld_funct3 = 3'd2; i_ld_rd = 5'd7;
    @(negedge i_clk);
    i_ld_valid = 1'b0;
    chk("rr_req1", o_mem_req, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    chk("rr_req0", o_mem_req, 0);
    chk("rr_nodone", o_ld_done, 0);
    chk("rr_ready", o_ld_ready, 1);
    chk("rr_data", o_ld_data, 0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk("rr_late_done", o_ld_done, 0);
    chk("rr_late_req", o_mem_req, 0);
    chk("rr_late_ready", o_ld_ready, 1);
    last_data = 32'd0;

`ifdef LOAD_TIMEOUT_EN
    @(negedge i_clk);
    i_ld_valid = 1'b1; i_ld_addr = 32'h80; i_ld_funct3 = 3'd2; i_ld_rd = 5'd12;
    for (int i = 1; i <= TO; i++) begin
      @(negedge i_clk);
      i_ld_valid = 1'b0;
      chk("to_req", o_mem_req, 1);
      chk("to_nodone", o_ld_done, 0);
    end
    @(negedge i_clk);
    chk("to_done", o_ld_done, 1);
    chk("to_fault", o_ld_fault, 3);
    chk("to_data", o_ld_data, 0);
    chk("to_rd", o_ld_rd_out, 12);
    chk("to_noreq", o_mem_req, 0);
    last_data = 32'd0;
    do_load(32'h0000_0084, 3'd2, 5'd13, 32'h0BAD_CAFE, TO, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      do_load($urandom, f3_tbl[$urandom_range(0, 7)], 5'($urandom),
              $urandom, $urandom_range(1, 4), 1'($urandom));
    end

    @(negedge i_clk);
    chk("end_ready", o_ld_ready, 1);
    chk("end_done", o_ld_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
